// File: rtl/reaction_round_ctrl.sv
// Reaction game round sequencer: difficulty select, target, count, score.
// Button edge detection, LED score bar and multi-round score accumulation.
module reaction_round_ctrl #(
  parameter int EASY_TICKS = 1000000,
  parameter int REG_TICKS  = 200000,
  parameter int HARD_TICKS = 100000,
  parameter int NUM_ROUNDS = 5,
  parameter int LED_STEP   = 30,
  parameter int MAX_COUNT  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_sel,
  input  logic [13:0] rand_in,
  output logic [1:0]  select,
  output logic [1:0]  mode,
  output logic [13:0] number,
  output logic [15:0] led,
  output logic [2:0]  round,
  output logic [15:0] total_score,
  output logic        game_over
);

  localparam int MAX_ER = (EASY_TICKS > REG_TICKS) ? EASY_TICKS : REG_TICKS;
  localparam int MAXT   = (MAX_ER > HARD_TICKS) ? MAX_ER : HARD_TICKS;
  localparam int TW     = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [TW-1:0] LAST_E = TW'(EASY_TICKS - 1);
  localparam logic [TW-1:0] LAST_R = TW'(REG_TICKS - 1);
  localparam logic [TW-1:0] LAST_H = TW'(HARD_TICKS - 1);
  localparam logic [13:0]   MAX_N  = 14'(MAX_COUNT);
  localparam logic [2:0]    LAST_RD = 3'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    S_MODE   = 2'd0,
    S_TARGET = 2'd1,
    S_COUNT  = 2'd2,
    S_SCORE  = 2'd3
  } state_t;

  state_t state, state_d;

  logic [1:0]    mode_d;
  logic [13:0]   number_d;
  logic [15:0]   led_d;
  logic [2:0]    round_d;
  logic [15:0]   total_d;
  logic          over_d;
  logic [13:0]   target, target_d;
  logic [TW-1:0] tick, tick_d;
  logic [TW-1:0] last_tick;

  logic up_q, dn_q, sel_q;
  logic up_p, dn_p, sel_p;
  logic [13:0] rnd_t;

  assign up_p   = btn_up & ~up_q;
  assign dn_p   = btn_down & ~dn_q;
  assign sel_p  = btn_sel & ~sel_q;
  assign rnd_t  = (rand_in == 14'd0) ? 14'd1 : rand_in;
  assign select = state;

  always_comb begin
    last_tick = LAST_H;
    unique case (1'b1)
      mode == 2'd0: last_tick = LAST_E;
      mode == 2'd1: last_tick = LAST_R;
      default:      last_tick = LAST_H;
    endcase
  end

  // Scoring: LED count found by a threshold compare chain, not a divider.
  logic [13:0] err;
  logic [4:0]  off;
  logic [16:0] mask;
  logic [15:0] led_new;
  logic [4:0]  pts;
  logic [16:0] sum;
  logic [15:0] total_new;

  always_comb begin
    err = (number >= target) ? (number - target) : (target - number);
    off = 5'd0;
    for (int k = 1; k <= 16; k++) begin
      if (int'(err) >= k * LED_STEP) off = off + 5'd1;
    end
    mask      = (17'd1 << off) - 17'd1;
    led_new   = ~mask[15:0];
    pts       = 5'd16 - off;
    sum       = {1'b0, total_score} + {12'd0, pts};
    total_new = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_comb begin
    state_d  = state;
    mode_d   = mode;
    number_d = number;
    led_d    = led;
    round_d  = round;
    total_d  = total_score;
    over_d   = game_over;
    target_d = target;
    tick_d   = tick;
    unique case (state)
      S_MODE: begin
        if (up_p && !dn_p && mode != 2'd2) begin
          mode_d = mode + 2'd1;
        end else if (dn_p && !up_p && mode != 2'd0) begin
          mode_d = mode - 2'd1;
        end
        if (sel_p) begin
          state_d  = S_TARGET;
          round_d  = 3'd0;
          total_d  = 16'd0;
          led_d    = 16'd0;
          target_d = rnd_t;
        end
      end
      S_TARGET: begin
        number_d = target;
        if (sel_p) begin
          state_d  = S_COUNT;
          number_d = 14'd0;
          tick_d   = '0;
        end
      end
      S_COUNT: begin
        if (sel_p || number == MAX_N) begin
          state_d = S_SCORE;
          led_d   = led_new;
          total_d = total_new;
          if (round == LAST_RD) over_d = 1'b1;
        end else if (tick == last_tick) begin
          tick_d   = '0;
          number_d = number + 14'd1;
        end else begin
          tick_d = tick + 1'b1;
        end
      end
      S_SCORE: begin
        if (sel_p) begin
          if (game_over) begin
            state_d  = S_MODE;
            number_d = 14'd0;
            led_d    = 16'd0;
            over_d   = 1'b0;
          end else begin
            state_d  = S_TARGET;
            round_d  = round + 3'd1;
            target_d = rnd_t;
          end
        end
      end
      default: state_d = S_MODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_MODE;
      mode        <= 2'd1;
      number      <= 14'd0;
      led         <= 16'd0;
      round       <= 3'd0;
      total_score <= 16'd0;
      game_over   <= 1'b0;
      target      <= 14'd0;
      tick        <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      state       <= state_d;
      mode        <= mode_d;
      number      <= number_d;
      led         <= led_d;
      round       <= round_d;
      total_score <= total_d;
      game_over   <= over_d;
      target      <= target_d;
      tick        <= tick_d;
      up_q        <= btn_up;
      dn_q        <= btn_down;
      sel_q       <= btn_sel;
    end
  end

endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Bench for reaction_round_ctrl: game-level reference model feeding a
// per-cycle scoreboard, plus directed scenarios and randomized play.
module tb_reaction_round_ctrl;

  localparam int ET = 10;
  localparam int RT = 4;
  localparam int HT = 2;
  localparam int NR = 2;
  localparam int LS = 30;
  localparam int MC = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_sel = 1'b0;
  logic [13:0] rand_in = 14'd0;
  logic [1:0]  select;
  logic [1:0]  mode;
  logic [13:0] number;
  logic [15:0] led;
  logic [2:0]  round;
  logic [15:0] total_score;
  logic        game_over;

  reaction_round_ctrl #(
    .EASY_TICKS(ET), .REG_TICKS(RT), .HARD_TICKS(HT),
    .NUM_ROUNDS(NR), .LED_STEP(LS), .MAX_COUNT(MC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
    .rand_in(rand_in),
    .select(select), .mode(mode), .number(number), .led(led),
    .round(round), .total_score(total_score), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask

  typedef struct {
    int sel; int md; int num; int led; int rd; int tot; int ov;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: game phases, elapsed-time counting, arithmetic scoring.
  int m_ph, m_md, m_num, m_tgt, m_el, m_led, m_rd, m_tot, m_ov;
  bit pu, pd, ps;

  function automatic int per(input int md);
    return (md == 0) ? ET : (md == 1) ? RT : HT;
  endfunction

  always @(posedge clk) begin
    bit u, d, s;
    int er, off;
    exp_t e;
    if (!rst_n) begin
      m_ph = 0; m_md = 1; m_num = 0; m_tgt = 0; m_el = 0;
      m_led = 0; m_rd = 0; m_tot = 0; m_ov = 0;
      pu = 0; pd = 0; ps = 0;
    end else begin
      u = btn_up && !pu;
      d = btn_down && !pd;
      s = btn_sel && !ps;
      pu = btn_up; pd = btn_down; ps = btn_sel;
      case (m_ph)
        0: begin
          if (u && !d) m_md = (m_md < 2) ? m_md + 1 : 2;
          else if (d && !u) m_md = (m_md > 0) ? m_md - 1 : 0;
          if (s) begin
            m_ph = 1; m_rd = 0; m_tot = 0; m_led = 0;
            m_tgt = (rand_in == 0) ? 1 : int'(rand_in);
          end
        end
        1: begin
          if (s) begin m_ph = 2; m_num = 0; m_el = 0; end
          else m_num = m_tgt;
        end
        2: begin
          if (s || m_num == MC) begin
            m_ph = 3;
            er = (m_num > m_tgt) ? m_num - m_tgt : m_tgt - m_num;
            off = er / LS;
            if (off > 16) off = 16;
            m_led = (32'hFFFF << off) & 32'hFFFF;
            m_tot = m_tot + 16 - off;
            if (m_tot > 65535) m_tot = 65535;
            if (m_rd == NR - 1) m_ov = 1;
          end else begin
            m_el++;
            m_num = m_el / per(m_md);
          end
        end
        default: begin
          if (s) begin
            if (m_ov != 0) begin
              m_ph = 0; m_num = 0; m_led = 0; m_ov = 0;
            end else begin
              m_ph = 1; m_rd++;
              m_tgt = (rand_in == 0) ? 1 : int'(rand_in);
            end
          end
        end
      endcase
    end
    e.sel = m_ph; e.md = m_md; e.num = m_num; e.led = m_led;
    e.rd = m_rd; e.tot = m_tot; e.ov = m_ov;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_select", select, e.sel);
      chk("sb_mode", mode, e.md);
      chk("sb_number", number, e.num);
      chk("sb_led", led, e.led);
      chk("sb_round", round, e.rd);
      chk("sb_total", total_score, e.tot);
      chk("sb_over", game_over, e.ov);
    end
  end

  task automatic setin(input logic u, input logic d, input logic s,
                       input logic [13:0] r);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_sel = s; rand_in = r;
  endtask

  task automatic press(input logic u, input logic d, input logic s,
                       input logic [13:0] r);
    setin(u, d, s, r);
    setin(1'b0, 1'b0, 1'b0, r);
  endtask

  task automatic idle(input int n);
    repeat (n) setin(1'b0, 1'b0, 1'b0, rand_in);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_select"}, select, 0);
    chk({tag, "_mode"}, mode, 1);
    chk({tag, "_number"}, number, 0);
    chk({tag, "_led"}, led, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_total"}, total_score, 0);
    chk({tag, "_over"}, game_over, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset("rst");

    press(1, 0, 0, 0); chk("up1", mode, 2);
    press(1, 0, 0, 0); chk("up2", mode, 2);
    press(1, 0, 0, 0); chk("up3", mode, 2);
    press(0, 1, 0, 0); chk("down1", mode, 1);
    press(1, 1, 0, 0); chk("updown", mode, 1);

    press(0, 0, 1, 14'd37); idle(2);
    chk("tgt_sel", select, 1);
    chk("tgt_num", number, 37);

    press(0, 0, 1, 14'd37); idle(40); press(0, 0, 1, 14'd37); idle(2);
    chk("r0_select", select, 3);
    chk("r0_number", number, 10);
    chk("r0_led", led, 16'hFFFF);
    chk("r0_total", total_score, 16);
    chk("r0_over", game_over, 0);

    press(0, 0, 1, 14'd100); idle(2);
    chk("r1_num", number, 100);
    chk("r1_round", round, 1);
    chk("r1_led_held", led, 16'hFFFF);
    press(0, 0, 1, 14'd100); idle(40); press(0, 0, 1, 14'd100); idle(2);
    chk("r1_number", number, 10);
    chk("r1_led", led, 16'hFFF8);
    chk("r1_total", total_score, 29);
    chk("r1_over", game_over, 1);

    press(0, 0, 1, 14'd9); idle(1);
    chk("go_select", select, 0);
    chk("go_led", led, 0);
    chk("go_number", number, 0);
    chk("go_over", game_over, 0);
    chk("go_total", total_score, 29);
    chk("go_mode", mode, 1);

    press(1, 0, 0, 0); chk("hard", mode, 2);
    press(0, 0, 1, 14'd0); idle(2);
    chk("zero_tgt", number, 1);
    chk("zero_total", total_score, 0);
    press(0, 0, 1, 14'd0); idle(110);
    chk("auto_select", select, 3);
    chk("auto_number", number, 50);
    chk("auto_led", led, 16'hFFFE);
    chk("auto_total", total_score, 15);
    chk("auto_over", game_over, 0);

    repeat (20) setin(0, 0, 1, 14'd5);
    idle(2);
    chk("hold_select", select, 1);
    chk("hold_round", round, 1);
    chk("hold_number", number, 5);

    press(0, 0, 1, 14'd5); idle(5);
    chk("cnt_select", select, 2);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_reset("midrst");
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 5) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 29) == 0) btn_sel = ~btn_sel;
      if ($urandom_range(0, 7) == 0) rand_in = 14'($urandom);
      else if ($urandom_range(0, 3) == 0) rand_in = 14'd0;
      else rand_in = 14'($urandom_range(0, 80));
      rst_n = ($urandom_range(0, 499) != 0);
    end
    rst_n = 1'b1;
    idle(3);
    @(negedge clk); #1;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
